ooo_ingress_arbiter: RTL and testbench

//  Packet-level round-robin arbiter sharing one OoOStation ingress thread among PORT_NUM requesters.

---
 rtl/ooo_ingress_arbiter_pkg.sv | 25 ++
 rtl/ooo_rr_pick.sv | 35 +++
 rtl/ooo_ingress_arbiter.sv | 107 ++++++++++
 tb/tb_ooo_ingress_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ooo_ingress_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ooo_ingress_arbiter_pkg
// Brief    : Shared types and helpers for the OoOStation ingress arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package ooo_ingress_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE_s = 2'd1,
        LOCK_s = 2'd2
    } arb_state_t;

    // Bits needed to represent x, never less than one.
    function automatic int log2b(input int x);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) <= x) r = i + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ooo_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : ooo_rr_pick
// Brief    : Combinational rotate-by-pointer priority pick over a request vector.
// Revision : 1.0 - initial release
// ============================================================================
module ooo_rr_pick #(
    parameter int PORT_NUM     = 4,
    parameter int PORT_NUM_LOG = 2
) (
    input  logic [PORT_NUM-1:0]     req,
    input  logic [PORT_NUM_LOG-1:0] ptr,
    output logic                    any,
    output logic [PORT_NUM_LOG-1:0] idx
);

    int w_cand;

    // Scan ptr, ptr+1, ... with explicit wrap so non-power-of-2 counts work.
    always_comb begin
        any    = 1'b0;
        idx    = '0;
        w_cand = 0;
        for (int i = 0; i < PORT_NUM; i++) begin
            w_cand = int'(ptr) + i;
            if (w_cand >= PORT_NUM) w_cand = w_cand - PORT_NUM;
            if (!any && req[w_cand]) begin
                any = 1'b1;
                idx = w_cand[PORT_NUM_LOG-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ooo_ingress_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ooo_ingress_arbiter
// Brief    : Packet-locked round-robin arbiter feeding one OoOStation ingress thread.
// Revision : 1.0 - initial release
// ============================================================================
module ooo_ingress_arbiter
    import ooo_ingress_arbiter_pkg::*;
#(
    parameter int PORT_NUM     = 4,
    parameter int PORT_NUM_LOG = log2b(PORT_NUM - 1),
    parameter int HEAD_WIDTH   = 160,
    parameter int DATA_WIDTH   = 512
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [PORT_NUM-1:0]            ingress_valid,
    input  logic [PORT_NUM*HEAD_WIDTH-1:0] ingress_head,
    input  logic [PORT_NUM*DATA_WIDTH-1:0] ingress_data,
    input  logic [PORT_NUM-1:0]            ingress_start,
    input  logic [PORT_NUM-1:0]            ingress_last,
    output logic [PORT_NUM-1:0]            ingress_ready,
    output logic                           out_valid,
    output logic [HEAD_WIDTH-1:0]          out_head,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic                           out_start,
    output logic                           out_last,
    input  logic                           out_ready,
    output logic                           grant_valid,
    output logic [PORT_NUM_LOG-1:0]        grant_idx
);

    localparam logic [PORT_NUM_LOG-1:0] c_last_idx = PORT_NUM_LOG'(PORT_NUM - 1);

    arb_state_t              r_state;
    logic [PORT_NUM_LOG-1:0] r_rr_ptr;
    logic [PORT_NUM_LOG-1:0] r_grant_idx;
    logic                    w_any;
    logic [PORT_NUM_LOG-1:0] w_pick_idx;
    logic [PORT_NUM_LOG-1:0] w_next_ptr;
    logic                    w_release;

    ooo_rr_pick #(
        .PORT_NUM     (PORT_NUM),
        .PORT_NUM_LOG (PORT_NUM_LOG)
    ) u_pick (
        .req (ingress_valid),
        .ptr (r_rr_ptr),
        .any (w_any),
        .idx (w_pick_idx)
    );

    assign w_release  = out_valid && out_ready && out_last;
    assign w_next_ptr = (r_grant_idx == c_last_idx) ? '0 : r_grant_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE_s;
            r_rr_ptr    <= '0;
            r_grant_idx <= '0;
        end else begin
            case (r_state)
                IDLE_s: begin
                    if (w_any) begin
                        r_grant_idx <= w_pick_idx;
                        r_state     <= LOCK_s;
                    end
                end
                LOCK_s: begin
                    // Only the last-beat handshake ends the packet; start is not policed.
                    if (w_release) begin
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= IDLE_s;
                    end
                end
                default: r_state <= IDLE_s;
            endcase
        end
    end

    // Output mux and ready demux driven from the registered grant only.
    always_comb begin
        out_valid     = 1'b0;
        out_head      = '0;
        out_data      = '0;
        out_start     = 1'b0;
        out_last      = 1'b0;
        ingress_ready = '0;
        if (r_state == LOCK_s) begin
            for (int i = 0; i < PORT_NUM; i++) begin
                if (r_grant_idx == PORT_NUM_LOG'(i)) begin
                    out_valid        = ingress_valid[i];
                    out_head         = ingress_head[i*HEAD_WIDTH +: HEAD_WIDTH];
                    out_data         = ingress_data[i*DATA_WIDTH +: DATA_WIDTH];
                    out_start        = ingress_start[i];
                    out_last         = ingress_last[i];
                    ingress_ready[i] = out_ready;
                end
            end
        end
    end

    assign grant_valid = (r_state == LOCK_s);
    assign grant_idx   = r_grant_idx;

endmodule
`default_nettype wire

// File: tb/tb_ooo_ingress_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ooo_ingress_arbiter
// Brief    : Directed, table-driven bench for the OoOStation ingress arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ooo_ingress_arbiter;

    localparam int N  = 4;
    localparam int HW = 16;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // Four-port instance
    logic [N-1:0]    iv, ist, il, ir;
    logic [HW-1:0]   hd [N];
    logic [N*HW-1:0] ih;
    logic [N*DW-1:0] idt;
    logic            ov, os, ol, ordy, gv;
    logic [HW-1:0]   oh;
    logic [DW-1:0]   od;
    logic [1:0]      gi;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            ih[i*HW +: HW]  = hd[i];
            idt[i*DW +: DW] = {~hd[i], hd[i]};
        end
    end

    ooo_ingress_arbiter #(
        .PORT_NUM   (N),
        .HEAD_WIDTH (HW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ingress_valid (iv),
        .ingress_head  (ih),
        .ingress_data  (idt),
        .ingress_start (ist),
        .ingress_last  (il),
        .ingress_ready (ir),
        .out_valid     (ov),
        .out_head      (oh),
        .out_data      (od),
        .out_start     (os),
        .out_last      (ol),
        .out_ready     (ordy),
        .grant_valid   (gv),
        .grant_idx     (gi)
    );

    // Three-port instance for the non-power-of-2 wrap
    logic [2:0]    iv3, ir3;
    logic          ov3, os3, ol3, gv3;
    logic [HW-1:0] oh3;
    logic [DW-1:0] od3;
    logic [1:0]    gi3;

    ooo_ingress_arbiter #(
        .PORT_NUM   (3),
        .HEAD_WIDTH (HW),
        .DATA_WIDTH (DW)
    ) dut3 (
        .clk           (clk),
        .rst           (rst),
        .ingress_valid (iv3),
        .ingress_head  ({16'hC200, 16'hC100, 16'hC000}),
        .ingress_data  ({3*DW{1'b0}}),
        .ingress_start (3'b111),
        .ingress_last  (3'b111),
        .ingress_ready (ir3),
        .out_valid     (ov3),
        .out_head      (oh3),
        .out_data      (od3),
        .out_start     (os3),
        .out_last      (ol3),
        .out_ready     (1'b1),
        .grant_valid   (gv3),
        .grant_idx     (gi3)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic        rdy;
        logic        e_ov;
        logic        e_gv;
        logic [1:0]  e_gi;
        logic [3:0]  e_ir;
        logic [15:0] e_head;
    } vec_t;

    vec_t tbl [11];

    initial begin
        // All ports offer single-beat packets back to back
        tbl[0]  = '{4'hF, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 16'h0000};
        tbl[1]  = '{4'hF, 1'b1, 1'b1, 1'b1, 2'd0, 4'b0001, 16'hA000};
        tbl[2]  = '{4'hF, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 16'h0000};
        tbl[3]  = '{4'hF, 1'b1, 1'b1, 1'b1, 2'd1, 4'b0010, 16'hA100};
        tbl[4]  = '{4'hF, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0000, 16'h0000};
        tbl[5]  = '{4'hF, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0100, 16'hA200};
        tbl[6]  = '{4'hF, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 16'h0000};
        tbl[7]  = '{4'hF, 1'b1, 1'b1, 1'b1, 2'd3, 4'b1000, 16'hA300};
        tbl[8]  = '{4'hF, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0000, 16'h0000};
        tbl[9]  = '{4'hF, 1'b1, 1'b1, 1'b1, 2'd0, 4'b0001, 16'hA000};
        tbl[10] = '{4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 16'h0000};

        rst  = 1'b0;
        iv   = '0;
        ist  = '0;
        il   = '0;
        ordy = 1'b0;
        iv3  = '0;
        for (int i = 0; i < N; i++) hd[i] = 16'hA000 + 16'(i * 256);

        repeat (3) tick();
        settle();
        chk("reset_ov", ov, 0);
        chk("reset_gv", gv, 0);
        chk("reset_gi", gi, 0);
        chk("reset_ir", ir, 0);
        chk("reset_rr", dut.r_rr_ptr, 0);
        chk("reset_state", dut.r_state, 2'd1);

        tick();
        rst = 1'b1;
        settle();

        // Round robin over four ports
        for (int k = 0; k < 11; k++) begin
            tick();
            iv   = tbl[k].valid;
            ist  = 4'hF;
            il   = 4'hF;
            ordy = tbl[k].rdy;
            settle();
            chk($sformatf("rr%0d_ov", k), ov, tbl[k].e_ov);
            chk($sformatf("rr%0d_gv", k), gv, tbl[k].e_gv);
            chk($sformatf("rr%0d_gi", k), gi, tbl[k].e_gi);
            chk($sformatf("rr%0d_ir", k), ir, tbl[k].e_ir);
            chk($sformatf("rr%0d_head", k), oh, tbl[k].e_head);
        end

        // Port 2 alone, three beats
        tick();
        iv = 4'b0100; ist = 4'b0100; il = 4'b0000; hd[2] = 16'hA200;
        settle();
        chk("p2_idle_ov", ov, 0);
        tick();
        settle();
        chk("p2_b0_ov", ov, 1);
        chk("p2_b0_gi", gi, 2);
        chk("p2_b0_head", oh, 16'hA200);
        chk("p2_b0_start", os, 1);
        chk("p2_b0_last", ol, 0);
        chk("p2_b0_ir", ir, 4'b0100);
        tick();
        hd[2] = 16'hA201; ist = 4'b0000;
        settle();
        chk("p2_b1_head", oh, 16'hA201);
        chk("p2_b1_data", od, {16'h5DFE, 16'hA201});
        tick();
        hd[2] = 16'hA202; il = 4'b0100;
        settle();
        chk("p2_b2_head", oh, 16'hA202);
        chk("p2_b2_last", ol, 1);
        tick();
        iv = 4'b0000; il = 4'b0000;
        settle();
        chk("p2_done_gv", gv, 0);
        chk("p2_done_ov", ov, 0);
        chk("p2_done_gi", gi, 2);
        chk("p2_done_rr", dut.r_rr_ptr, 3);
        chk("p2_done_state", dut.r_state, 2'd1);

        // Port 1 stalled by out_ready while port 0 waits
        tick();
        iv = 4'b0010; ist = 4'b0011; il = 4'b0011; ordy = 1'b0;
        hd[0] = 16'hA000; hd[1] = 16'hA100;
        settle();
        chk("stall_idle_ov", ov, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            iv = 4'b0011;
            settle();
            chk($sformatf("stall%0d_gi", k), gi, 1);
            chk($sformatf("stall%0d_ir", k), ir, 4'b0000);
            chk($sformatf("stall%0d_head", k), oh, 16'hA100);
        end
        tick();
        ordy = 1'b1;
        settle();
        chk("stall_rel_ir", ir, 4'b0010);
        chk("stall_rel_ov", ov, 1);
        tick();
        iv = 4'b0001;
        settle();
        chk("stall_gap_gv", gv, 0);
        chk("stall_gap_rr", dut.r_rr_ptr, 2);
        tick();
        settle();
        chk("stall_next_gi", gi, 0);
        chk("stall_next_head", oh, 16'hA000);
        chk("stall_next_ir", ir, 4'b0001);
        tick();
        iv = 4'b0000;
        settle();
        chk("stall_end_gv", gv, 0);

        // Port 3 drops valid for two cycles mid-packet
        tick();
        iv = 4'b1000; ist = 4'b1000; il = 4'b0000; hd[3] = 16'hA300;
        settle();
        tick();
        settle();
        chk("drop_b0_ov", ov, 1);
        chk("drop_b0_gi", gi, 3);
        chk("drop_b0_head", oh, 16'hA300);
        for (int k = 0; k < 2; k++) begin
            tick();
            iv = 4'b0000;
            settle();
            chk($sformatf("drop%0d_ov", k), ov, 0);
            chk($sformatf("drop%0d_gv", k), gv, 1);
            chk($sformatf("drop%0d_gi", k), gi, 3);
            chk($sformatf("drop%0d_ir", k), ir, 4'b1000);
        end
        tick();
        iv = 4'b1000; ist = 4'b0000; il = 4'b1000; hd[3] = 16'hA301;
        settle();
        chk("drop_b1_ov", ov, 1);
        chk("drop_b1_last", ol, 1);
        chk("drop_b1_head", oh, 16'hA301);
        tick();
        iv = 4'b0000; il = 4'b0000;
        settle();
        chk("drop_end_gv", gv, 0);
        chk("drop_end_rr", dut.r_rr_ptr, 0);

        // Reset during beat 2 of a 4-beat packet on port 2
        tick();
        iv = 4'b0100; ist = 4'b0100; il = 4'b0000; hd[2] = 16'hA200;
        settle();
        tick();
        settle();
        chk("rstmid_b0_gi", gi, 2);
        tick();
        hd[2] = 16'hA201; ist = 4'b0000; rst = 1'b0;
        settle();
        chk("rstmid_b1_head", oh, 16'hA201);
        tick();
        settle();
        chk("rstmid_ov", ov, 0);
        chk("rstmid_ir", ir, 4'b0000);
        chk("rstmid_gv", gv, 0);
        chk("rstmid_gi", gi, 0);
        chk("rstmid_rr", dut.r_rr_ptr, 0);
        chk("rstmid_state", dut.r_state, 2'd1);
        tick();
        rst = 1'b1; iv = 4'b0000;
        settle();

        // Three-port wrap: grant 2 completes, pointer returns to 0
        tick();
        iv3 = 3'b100;
        settle();
        chk("p3_idle_ov", ov3, 0);
        tick();
        settle();
        chk("p3_g2_gi", gi3, 2);
        chk("p3_g2_ov", ov3, 1);
        tick();
        iv3 = 3'b011;
        settle();
        chk("p3_gap_gv", gv3, 0);
        chk("p3_gap_rr", dut3.r_rr_ptr, 0);
        tick();
        settle();
        chk("p3_next_gi", gi3, 0);
        chk("p3_next_head", oh3, 16'hC000);
        chk("p3_next_ir", ir3, 3'b001);
        tick();
        iv3 = 3'b000;
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
